// File: rtl/counter.sv
// Free-running up-counter with a programmable terminal count and a one-cycle wrap strobe.
// Count and strobe are both registered, so downstream logic sees no combinational path from rst.
module counter #(
   parameter int unsigned     CNT_WIDTH = 5,
   parameter longint unsigned CNT_MAX   = (CNT_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                             : ((64'd1 << CNT_WIDTH) - 64'd1),
   parameter longint unsigned RST_VAL   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic                 o_wrap
);

   // Reject parameter sets that cannot be represented or would never reach the reset value.
   if (CNT_WIDTH < 1 || CNT_WIDTH > 64) begin : g_bad_width
      $fatal(1, "counter: CNT_WIDTH must be in 1..64");
   end
   if (CNT_WIDTH < 64 && (CNT_MAX >> CNT_WIDTH) != 0) begin : g_bad_max
      $fatal(1, "counter: CNT_MAX does not fit in CNT_WIDTH bits");
   end
   if (RST_VAL > CNT_MAX) begin : g_bad_rst
      $fatal(1, "counter: RST_VAL must not exceed CNT_MAX");
   end

   localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_MAX[CNT_WIDTH-1:0];
   localparam logic [CNT_WIDTH-1:0] LP_RST = RST_VAL[CNT_WIDTH-1:0];
   localparam logic                 LP_RST_WRAP = (LP_RST == LP_MAX);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_wrap;
   logic                 w_at_max;
   logic [CNT_WIDTH-1:0] w_cnt_next;
   logic                 w_wrap_next;

   // The strobe is computed from the next count so it lands in the same cycle as o_cnt == CNT_MAX.
   assign w_at_max    = (r_cnt == LP_MAX);
   assign w_cnt_next  = w_at_max ? '0 : r_cnt + CNT_WIDTH'(1);
   assign w_wrap_next = (w_cnt_next == LP_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= LP_RST;
         r_wrap <= LP_RST_WRAP;
      end else begin
         r_cnt  <= w_cnt_next;
         r_wrap <= w_wrap_next;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = r_wrap;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: five parameterisations share one clock and reset; the stimulus
// process queues the expected outputs for every edge and a monitor pops and compares them.
module tb_counter;

   logic clk;
   logic rst;

   logic [4:0] cnt_def, cnt_m9, cnt_r30;
   logic [2:0] cnt_m0;
   logic [0:0] cnt_w1;
   logic       wrap_def, wrap_m9, wrap_r30, wrap_m0, wrap_w1;

   counter u_def (.clk(clk), .rst(rst), .o_cnt(cnt_def), .o_wrap(wrap_def));
   counter #(.CNT_WIDTH(5), .CNT_MAX(9)) u_m9 (.clk(clk), .rst(rst), .o_cnt(cnt_m9), .o_wrap(wrap_m9));
   counter #(.CNT_WIDTH(5), .RST_VAL(30)) u_r30 (.clk(clk), .rst(rst), .o_cnt(cnt_r30), .o_wrap(wrap_r30));
   counter #(.CNT_WIDTH(3), .CNT_MAX(0)) u_m0 (.clk(clk), .rst(rst), .o_cnt(cnt_m0), .o_wrap(wrap_m0));
   counter #(.CNT_WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .o_cnt(cnt_w1), .o_wrap(wrap_w1));

   typedef struct packed {
      logic [63:0] c_def;  logic w_def;
      logic [63:0] c_m9;   logic w_m9;
      logic [63:0] c_r30;  logic w_r30;
      logic [63:0] c_m0;   logic w_m0;
      logic [63:0] c_w1;   logic w_w1;
      logic        rst_edge;
   } exp_t;

   typedef struct packed {
      logic        rst_val;
      int unsigned n_edges;
   } phase_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fails  = 0;
   int n_obs    = 0;
   int wraps_def = 0, wraps_m9 = 0, wraps_r30 = 0, wraps_m0 = 0, wraps_w1 = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint unsigned act, input longint unsigned req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s edge %0d: got %0d, required %0d", name, n_obs, act, req);
      end
   endtask

   // Closed-form expectation: k edges after the last reset edge.
   function automatic longint unsigned exp_cnt(input longint unsigned rv, input longint unsigned mx,
                                               input int unsigned k);
      return (rv + longint'(k)) % (mx + 1);
   endfunction

   // Monitor: every edge presents a new output, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_obs++;
            check("def_cnt",  64'(cnt_def), e.c_def);  check("def_wrap", 64'(wrap_def), 64'(e.w_def));
            check("m9_cnt",   64'(cnt_m9),  e.c_m9);   check("m9_wrap",  64'(wrap_m9),  64'(e.w_m9));
            check("r30_cnt",  64'(cnt_r30), e.c_r30);  check("r30_wrap", 64'(wrap_r30), 64'(e.w_r30));
            check("m0_cnt",   64'(cnt_m0),  e.c_m0);   check("m0_wrap",  64'(wrap_m0),  64'(e.w_m0));
            check("w1_cnt",   64'(cnt_w1),  e.c_w1);   check("w1_wrap",  64'(wrap_w1),  64'(e.w_w1));
            if (wrap_def === 1'b1) wraps_def++;
            if (wrap_m9  === 1'b1) wraps_m9++;
            if (wrap_r30 === 1'b1) wraps_r30++;
            if (wrap_m0  === 1'b1) wraps_m0++;
            if (wrap_w1  === 1'b1) wraps_w1++;
            $display("edge %0d rst=%0d def=%0d/%0d m9=%0d/%0d r30=%0d/%0d m0=%0d/%0d w1=%0d/%0d",
                     n_obs, e.rst_edge, cnt_def, wrap_def, cnt_m9, wrap_m9, cnt_r30, wrap_r30,
                     cnt_m0, wrap_m0, cnt_w1, wrap_w1);
         end
      end
   end

   // Stimulus: 2 reset edges, 113 free-run edges (default counter sits at 17 afterwards),
   // a single mid-count reset edge, 40 free-run edges, 3 held reset edges, 12 free-run edges.
   phase_t phases [6] = '{'{1'b1, 2}, '{1'b0, 113}, '{1'b1, 1}, '{1'b0, 40}, '{1'b1, 3}, '{1'b0, 12}};

   initial begin
      exp_t        e;
      int unsigned k;
      k   = 0;
      rst = 1'b1;
      foreach (phases[p]) begin
         for (int unsigned i = 0; i < phases[p].n_edges; i++) begin
            rst = phases[p].rst_val;
            if (rst) k = 0;
            else     k++;
            e.rst_edge = rst;
            e.c_def = rst ? 64'd0  : exp_cnt(0, 31, k);
            e.c_m9  = rst ? 64'd0  : exp_cnt(0, 9, k);
            e.c_r30 = rst ? 64'd30 : exp_cnt(30, 31, k);
            e.c_m0  = 64'd0;
            e.c_w1  = rst ? 64'd0  : exp_cnt(0, 1, k);
            e.w_def = (e.c_def == 31);
            e.w_m9  = (e.c_m9 == 9);
            e.w_r30 = (e.c_r30 == 31);
            e.w_m0  = 1'b1;
            e.w_w1  = (e.c_w1 == 1);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
         end
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      // Hand-counted totals over the 171 edges of the schedule above.
      check("edges_observed", 64'(n_obs), 64'd171);
      check("queue_drained",  64'(exp_q.size()), 64'd0);
      check("def_wraps",  64'(wraps_def), 64'd4);
      check("m9_wraps",   64'(wraps_m9),  64'd16);
      check("r30_wraps",  64'(wraps_r30), 64'd7);
      check("m0_wraps",   64'(wraps_m0),  64'd171);
      check("w1_wraps",   64'(wraps_w1),  64'd83);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
